// File: rtl/sseg_scan_decoder.sv
// Seven-segment scan monitor: rebuilds 8 hex digits from AN/sseg/DP pin traffic.
// Define DP_CAPTURE_EN to capture decimal points and include DP in settling.
module sseg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  AN,
  input  logic [6:0]  sseg,
  input  logic        DP,
  output logic [31:0] digit_val,
  output logic [7:0]  digit_ok,
  output logic [7:0]  dp_val,
  output logic        frame_done,
  output logic        bad_pattern,
  output logic        multi_err
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [7:0] CAP_AT = 8'(SETTLE_CYCLES - 1);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] CAPTURED = 1'b1;

  logic [7:0] an_q;
  logic [7:0] an_p;
  logic [6:0] seg_q;
  logic [6:0] seg_p;
  logic       changed;

  logic [7:0] cnt;
  logic [0:0] state;
  logic [7:0] seen;

  logic [7:0] an_low;
  logic       blank;
  logic       legal;
  logic       multi;
  logic [2:0] idx;

  logic [6:0] seg_on;
  logic       glyph_ok;
  logic [3:0] nib;

  logic       cap;
  logic       cap_digit;
  logic       cap_multi;
  logic [7:0] cap_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
      an_p  <= 8'hFF;
      seg_p <= 7'h7F;
    end else begin
      an_q  <= AN;
      seg_q <= sseg;
      an_p  <= an_q;
      seg_p <= seg_q;
    end
  end

`ifdef DP_CAPTURE_EN
  logic dp_q;
  logic dp_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_q <= 1'b1;
      dp_p <= 1'b1;
    end else begin
      dp_q <= DP;
      dp_p <= dp_q;
    end
  end

  assign changed = (an_q != an_p) ||
                   (seg_q != seg_p) ||
                   (dp_q != dp_p);

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_val <= 8'h00;
    end else if (cap_digit) begin
      dp_val[idx] <= ~dp_q;
    end
  end
`else
  logic unused_dp;

  assign unused_dp = DP;
  assign changed   = (an_q != an_p) ||
                     (seg_q != seg_p);
  assign dp_val    = 8'h00;
`endif

  always_comb begin
    an_low = ~an_q;
    blank  = (an_q == 8'hFF);
    legal  = !blank &&
             ((an_low & (an_low - 8'd1)) == 8'h00);
    multi  = !blank && !legal;
    idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_low[i]) idx = 3'(i);
    end
  end

  assign seg_on = ~seg_q;

  always_comb begin
    glyph_ok = 1'b1;
    nib      = 4'h0;
    case (seg_on)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  // One capture per dwell: only from IDLE, and only on a quiet cycle.
  assign cap       = (state == IDLE) && !changed &&
                     (cnt == CAP_AT) && !blank;
  assign cap_digit = cap && legal;
  assign cap_multi = cap && multi;
  assign cap_mask  = cap_digit ? (8'h01 << idx) : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 8'd0;
      state <= IDLE;
    end else if (changed) begin
      cnt   <= 8'd0;
      state <= IDLE;
    end else begin
      if (cnt != SETTLE) cnt <= cnt + 8'd1;
      if (cap) state <= CAPTURED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_val   <= 32'h0;
      digit_ok    <= 8'h00;
      bad_pattern <= 1'b0;
      multi_err   <= 1'b0;
    end else begin
      bad_pattern <= cap_digit && !glyph_ok;
      if (cap_digit) begin
        if (glyph_ok) digit_val[{idx, 2'b00} +: 4] <= nib;
        digit_ok[idx] <= glyph_ok;
      end
      if (cap_multi) multi_err <= 1'b1;
    end
  end

  // A full mask pulses and restarts; a capture landing now seeds the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen       <= 8'h00;
      frame_done <= 1'b0;
    end else if (seen == 8'hFF) begin
      seen       <= cap_mask;
      frame_done <= 1'b1;
    end else begin
      seen       <= seen | cap_mask;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder (SETTLE_CYCLES = 4).
// Pins change #1 after a rising edge; outputs sampled at the same point.
module tb_sseg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  AN;
  logic [6:0]  sseg;
  logic        DP;
  logic [31:0] digit_val;
  logic [7:0]  digit_ok;
  logic [7:0]  dp_val;
  logic        frame_done;
  logic        bad_pattern;
  logic        multi_err;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int bp_cnt = 0;

  logic [6:0] gly [0:7] = '{7'h40, 7'h79, 7'h24, 7'h30,
                            7'h19, 7'h12, 7'h02, 7'h78};

`ifdef DP_CAPTURE_EN
  localparam logic [7:0] DP_EXP = 8'h20;
`else
  localparam logic [7:0] DP_EXP = 8'h00;
`endif

  sseg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .AN          (AN),
    .sseg        (sseg),
    .DP          (DP),
    .digit_val   (digit_val),
    .digit_ok    (digit_ok),
    .dp_val      (dp_val),
    .frame_done  (frame_done),
    .bad_pattern (bad_pattern),
    .multi_err   (multi_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) fd_cnt++;
      if (bad_pattern === 1'b1) bp_cnt++;
    end
  endtask

  task automatic drive(input logic [7:0] an,
                       input logic [6:0] sg,
                       input logic dp);
    AN   = an;
    sseg = sg;
    DP   = dp;
  endtask

  task automatic dwell(input logic [7:0] an,
                       input logic [6:0] sg,
                       input logic dp,
                       input int n);
    drive(an, sg, dp);
    step(n);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(8'hFC, 7'h00, 1'b0);
    step(3);
    checks++;
    if ({digit_val, digit_ok, dp_val, frame_done,
         bad_pattern, multi_err} !== 51'h0) begin
      errors++;
      $display("FAIL reset_outs got %h/%h/%h/%b%b%b exp 0",
               digit_val, digit_ok, dp_val,
               frame_done, bad_pattern, multi_err);
    end
    reset = 1'b0;
    drive(8'hFF, 7'h7F, 1'b1);
    step(3);
    checks++;
    if ({digit_val, digit_ok, multi_err} !== 41'h0) begin
      errors++;
      $display("FAIL post_reset got %h/%h/%b exp 0",
               digit_val, digit_ok, multi_err);
    end
  endtask

  task automatic test_settle;
    bp_cnt = 0;
    drive(8'hFE, 7'h30, 1'b1);
    step(5);
    checks++;
    if (digit_ok[0] !== 1'b0) begin
      errors++;
      $display("FAIL settle_early got %b exp 0", digit_ok[0]);
    end
    step(1);
    checks++;
    if (digit_val[3:0] !== 4'h3) begin
      errors++;
      $display("FAIL settle_val got %h exp 3", digit_val[3:0]);
    end
    checks++;
    if (digit_ok[0] !== 1'b1) begin
      errors++;
      $display("FAIL settle_ok got %b exp 1", digit_ok[0]);
    end
    step(4);
    checks++;
    if (bp_cnt != 0 || fd_cnt != 0) begin
      errors++;
      $display("FAIL settle_pulses got bp=%0d fd=%0d exp 0",
               bp_cnt, fd_cnt);
    end
    dwell(8'hFF, 7'h7F, 1'b1, 3);
  endtask

  task automatic test_short_dwell;
    dwell(8'hFD, 7'h79, 1'b1, 3);
    dwell(8'hFF, 7'h7F, 1'b1, 8);
    checks++;
    if (digit_val[7:4] !== 4'h0 || digit_ok[1] !== 1'b0) begin
      errors++;
      $display("FAIL short_dwell got %h/%b exp 0/0",
               digit_val[7:4], digit_ok[1]);
    end
  endtask

  task automatic test_scan;
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      dwell(~(8'h01 << i), gly[i], 1'(i != 5), 6);
    end
    checks++;
    if (frame_done !== 1'b0 || fd_cnt != 0) begin
      errors++;
      $display("FAIL scan_fd_early got %b/%0d exp 0/0",
               frame_done, fd_cnt);
    end
    drive(8'hFF, 7'h7F, 1'b1);
    step(1);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL scan_fd_pulse got %b exp 1", frame_done);
    end
    step(1);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL scan_fd_end got %b exp 0", frame_done);
    end
    step(4);
    checks++;
    if (fd_cnt != 1) begin
      errors++;
      $display("FAIL scan_fd_count got %0d exp 1", fd_cnt);
    end
    checks++;
    if (digit_val !== 32'h76543210) begin
      errors++;
      $display("FAIL scan_val got %h exp 76543210", digit_val);
    end
    checks++;
    if (digit_ok !== 8'hFF) begin
      errors++;
      $display("FAIL scan_ok got %h exp ff", digit_ok);
    end
    checks++;
    if (dp_val !== DP_EXP) begin
      errors++;
      $display("FAIL scan_dp got %h exp %h", dp_val, DP_EXP);
    end
  endtask

  task automatic test_bad_glyph;
    dwell(8'hFB, 7'h00, 1'b1, 6);
    checks++;
    if (digit_val[11:8] !== 4'h8 || digit_ok[2] !== 1'b1) begin
      errors++;
      $display("FAIL glyph8 got %h/%b exp 8/1",
               digit_val[11:8], digit_ok[2]);
    end
    bp_cnt = 0;
    drive(8'hFB, 7'h7F, 1'b1);
    step(5);
    checks++;
    if (bp_cnt != 0) begin
      errors++;
      $display("FAIL bad_early got %0d exp 0", bp_cnt);
    end
    step(1);
    checks++;
    if (bad_pattern !== 1'b1) begin
      errors++;
      $display("FAIL bad_pulse got %b exp 1", bad_pattern);
    end
    checks++;
    if (digit_val[11:8] !== 4'h8 || digit_ok[2] !== 1'b0) begin
      errors++;
      $display("FAIL bad_keep got %h/%b exp 8/0",
               digit_val[11:8], digit_ok[2]);
    end
    step(3);
    checks++;
    if (bp_cnt != 1) begin
      errors++;
      $display("FAIL bad_count got %0d exp 1", bp_cnt);
    end
    dwell(8'hFF, 7'h7F, 1'b1, 3);
  endtask

  task automatic test_multi;
    dwell(8'hFC, 7'h7F, 1'b1, 5);
    checks++;
    if (multi_err !== 1'b0) begin
      errors++;
      $display("FAIL multi_early got %b exp 0", multi_err);
    end
    step(1);
    checks++;
    if (multi_err !== 1'b1) begin
      errors++;
      $display("FAIL multi_set got %b exp 1", multi_err);
    end
    dwell(8'hFF, 7'h7F, 1'b1, 6);
    checks++;
    if (multi_err !== 1'b1) begin
      errors++;
      $display("FAIL multi_sticky got %b exp 1", multi_err);
    end
    checks++;
    if (digit_val !== 32'h76543810 || digit_ok !== 8'hFB) begin
      errors++;
      $display("FAIL multi_nowrite got %h/%h exp 76543810/fb",
               digit_val, digit_ok);
    end
  endtask

  task automatic test_reset_midframe;
    fd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      dwell(~(8'h01 << i), gly[i], 1'b1, 6);
    end
    dwell(8'hFF, 7'h7F, 1'b1, 2);
    checks++;
    if (fd_cnt != 0) begin
      errors++;
      $display("FAIL mid_no_fd got %0d exp 0", fd_cnt);
    end
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);
    checks++;
    if ({digit_val, digit_ok, multi_err} !== 41'h0) begin
      errors++;
      $display("FAIL mid_reset got %h/%h/%b exp 0",
               digit_val, digit_ok, multi_err);
    end
    for (int i = 4; i < 8; i++) begin
      dwell(~(8'h01 << i), gly[i], 1'b1, 6);
    end
    dwell(8'hFF, 7'h7F, 1'b1, 4);
    checks++;
    if (fd_cnt != 0) begin
      errors++;
      $display("FAIL mid_half_fd got %0d exp 0", fd_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      dwell(~(8'h01 << i), gly[i], 1'b1, 6);
    end
    dwell(8'hFF, 7'h7F, 1'b1, 4);
    checks++;
    if (fd_cnt != 1) begin
      errors++;
      $display("FAIL mid_full_fd got %0d exp 1", fd_cnt);
    end
    checks++;
    if (digit_val !== 32'h76543210 || digit_ok !== 8'hFF) begin
      errors++;
      $display("FAIL mid_vals got %h/%h exp 76543210/ff",
               digit_val, digit_ok);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_settle();
    test_short_dwell();
    test_scan();
    test_bad_glyph();
    test_multi();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
